// File: rtl/button_conditioner.sv
// Push-switch conditioner: 2-flop sync, debounce FSM, press/release pulses per channel.
// Optional hold-to-repeat pulse train is built only when BTN_AUTOREPEAT_EN is defined.

module btn_lane #(
  parameter int DB_CYCLES     = 20000,
  parameter int REPEAT_DELAY  = 500000,
  parameter int REPEAT_PERIOD = 100000,
  parameter bit RPT_EN        = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_ONE  = DBW'(1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_e;

  logic [1:0]     sync_q;
  logic           sync;
  state_e         state_q, state_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           level_q, level_d;
  logic           press_q, press_d;
  logic           release_q, release_d;

  assign sync = sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= 2'b00;
      state_q   <= IDLE;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], raw_i};
      state_q   <= state_d;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // db_cnt counts consecutive samples that disagree with the accepted level.
  always_comb begin
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync) begin
          if (DB_CYCLES == 1) begin
            state_d  = HELD;
            level_d  = 1'b1;
            press_d  = 1'b1;
            db_cnt_d = '0;
          end else begin
            state_d  = PRESS_WAIT;
            db_cnt_d = DB_ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!sync) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = HELD;
          level_d  = 1'b1;
          press_d  = 1'b1;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      HELD: begin
        if (!sync) begin
          if (DB_CYCLES == 1) begin
            state_d   = IDLE;
            level_d   = 1'b0;
            release_d = 1'b1;
            db_cnt_d  = '0;
          end else begin
            state_d  = RELEASE_WAIT;
            db_cnt_d = DB_ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        if (sync) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
          db_cnt_d  = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef BTN_AUTOREPEAT_EN
  if (RPT_EN) begin : g_rpt
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RPT_ONE     = RW'(1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic {PH_DELAY, PH_PERIOD} phase_e;

    phase_e        phase_q, phase_d;
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          repeat_q, repeat_d;
    logic [RW-1:0] rpt_last;

    assign rpt_last = (phase_q == PH_PERIOD) ? PERIOD_LAST : DELAY_LAST;

    // Counter only advances in HELD; RELEASE_WAIT freezes it so a bounce resumes the train.
    always_comb begin
      phase_d   = phase_q;
      rpt_cnt_d = rpt_cnt_q;
      repeat_d  = 1'b0;
      if (press_d) begin
        phase_d   = PH_DELAY;
        rpt_cnt_d = '0;
      end else if (state_q == HELD) begin
        if (rpt_cnt_q == rpt_last) begin
          repeat_d  = 1'b1;
          rpt_cnt_d = '0;
          phase_d   = PH_PERIOD;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RPT_ONE;
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        phase_q   <= PH_DELAY;
        rpt_cnt_q <= '0;
        repeat_q  <= 1'b0;
      end else begin
        phase_q   <= phase_d;
        rpt_cnt_q <= rpt_cnt_d;
        repeat_q  <= repeat_d;
      end
    end

    assign repeat_o = repeat_q;
  end else begin : g_norpt
    assign repeat_o = 1'b0;
  end
`else
  assign repeat_o = 1'b0;
  // Repeat timing parameters are accepted but have no hardware in this build.
  if (RPT_EN && (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)) begin : g_rpt_cfg_unused
  end
`endif

endmodule

module button_conditioner #(
  parameter int               N_BTN         = 6,
  parameter int               DB_CYCLES     = 20000,
  parameter int               REPEAT_DELAY  = 500000,
  parameter int               REPEAT_PERIOD = 100000,
  parameter logic [N_BTN-1:0] REPEAT_MASK   = 6'b001100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    btn_lane #(
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .RPT_EN       (REPEAT_MASK[i])
    ) u_lane (
      .clk_i    (clk),
      .rst_ni   (reset),
      .raw_i    (btn_raw[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .repeat_o (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a run-length reference model predicts
// every output cycle; a negedge monitor pops and compares.

module tb_button_conditioner;

  localparam int N  = 6;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam logic [N-1:0] MASK = 6'b001100;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit RPT_BUILT = 1'b1;
`else
  localparam bit RPT_BUILT = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] raw   = '0;
  logic [N-1:0] level, press, rel, rpt;

  int checks = 0;
  int errors = 0;

  button_conditioner #(
    .N_BTN(N), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk), .reset(rst_n), .btn_raw(raw),
    .btn_level(level), .btn_press(press), .btn_release(rel), .btn_repeat(rpt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] rpt;
  } exp_t;

  exp_t exp_q[$];

  // Reference: a level flips once the synchronized input has disagreed with it for
  // DB consecutive samples; repeats count cycles spent fully settled at level 1.
  bit m_s1[N], m_s2[N], m_lvl[N], m_first[N];
  int m_run[N], m_hold[N];

  always @(posedge clk) begin
    exp_t e;
    e = '0;
    for (int c = 0; c < N; c++) begin
      if (!rst_n) begin
        m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_lvl[c] = 1'b0; m_first[c] = 1'b1;
        m_run[c] = 0;   m_hold[c] = 0;
      end else begin
        if (RPT_BUILT && MASK[c] && m_lvl[c] && m_run[c] == 0) begin
          m_hold[c]++;
          if (m_hold[c] == (m_first[c] ? RD : RP)) begin
            e.rpt[c]   = 1'b1;
            m_hold[c]  = 0;
            m_first[c] = 1'b0;
          end
        end
        if (m_s2[c] != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == DB) begin
            m_lvl[c] = m_s2[c];
            m_run[c] = 0;
            if (m_lvl[c]) begin
              e.press[c] = 1'b1;
              m_hold[c]  = 0;
              m_first[c] = 1'b1;
            end else begin
              e.rel[c] = 1'b1;
            end
          end
        end else begin
          m_run[c] = 0;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = raw[c];
      end
      e.level[c] = m_lvl[c];
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty t=%0t got lvl=%h prs=%h rel=%h rpt=%h", $time, level, press, rel, rpt);
    end else begin
      e = exp_q.pop_front();
      if ({level, press, rel, rpt} !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got lvl=%h prs=%h rel=%h rpt=%h want lvl=%h prs=%h rel=%h rpt=%h",
                 $time, level, press, rel, rpt, e.level, e.press, e.rel, e.rpt);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check_clear(input string tag);
    checks++;
    if ({level, press, rel, rpt} !== '0) begin
      errors++;
      $display("FAIL %s t=%0t got lvl=%h prs=%h rel=%h rpt=%h want all 0", tag, $time, level, press, rel, rpt);
    end
  endtask

  initial begin
    // Buttons held through reset, then seen as fresh presses.
    raw = 6'h3F; rst_n = 1'b0;
    cycles(3);
    check_clear("reset_hold");
    rst_n = 1'b1;
    cycles(14);
    raw = '0;
    cycles(10);

    // Short glitches on channel 0.
    for (int k = 0; k < 2; k++) begin
      raw[0] = 1'b1; cycles(2);
      raw[0] = 1'b0; cycles(2);
    end
    cycles(10);

    // Long hold on a repeat channel, then on a non-repeat channel.
    raw[2] = 1'b1; cycles(40);
    raw[2] = 1'b0; cycles(10);
    raw[0] = 1'b1; cycles(40);
    raw[0] = 1'b0; cycles(10);

    // Asynchronous reset in the middle of a repeat train.
    raw[3] = 1'b1; cycles(22);
    #2;
    rst_n = 1'b0;
    #1;
    check_clear("async_reset");
    cycles(2);
    rst_n = 1'b1;
    cycles(30);
    raw[3] = 1'b0;
    cycles(10);

    // Random bouncing with occasional resets; repeat channels bounce less often.
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, MASK[c] ? 39 : 7) == 0) raw[c] = ~raw[c];
      rst_n = ($urandom_range(0, 699) != 0);
      cycles(1);
    end
    rst_n = 1'b1;
    raw   = '0;
    cycles(20);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the six raw board push switches into clean, debounced levels and single-cycle event pulses for the mode/set/up/down/reset control logic and display logic. The block is the input-side counterpart of the segment/LED output path. It sits between the push-switch pins and the mode controller. Per button it provides a two-flop synchronizer, a debounce counter, press and release pulses, and an optional hold-to-repeat pulse train for up/down adjustment.

## Interface
Parameters:
- N_BTN, 6, number of independent button channels
- DB_CYCLES, 20000, consecutive stable cycles required to accept a level change (≥1)
- REPEAT_DELAY, 500000, cycles a button must be held before the first repeat pulse (≥1)
- REPEAT_PERIOD, 100000, cycles between subsequent repeat pulses (≥1)
- REPEAT_MASK, 6'b001100, per-channel repeat enable (bit i = channel i)

Ports:
- clk  input  1  board clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset
- btn_raw  input  N_BTN  raw push-switch levels, active-high, asynchronous to clk
- btn_level  output  N_BTN  debounced level per channel
- btn_press  output  N_BTN  one-cycle pulse on accepted 0→1 transition
- btn_release  output  N_BTN  one-cycle pulse on accepted 1→0 transition
- btn_repeat  output  N_BTN  one-cycle repeat pulse while held (see Configuration)

## Operation
- Channels are fully independent. Identical logic per channel.
- Synchronizer: btn_raw[i] passes through two flops, giving sync[i]. Only sync[i] feeds logic.
- Per-channel FSM:
  - IDLE: level=0. A sync value of 1 loads db_cnt=1 and moves to PRESS_WAIT.
  - PRESS_WAIT: sync=1 increments db_cnt. Reaching DB_CYCLES goes to HELD, sets level=1, and pulses press. sync=0 returns to IDLE and clears db_cnt. Any bounce restarts the debounce.
  - HELD: level=1. A sync value of 0 loads db_cnt=1 and moves to RELEASE_WAIT. The repeat counter runs here.
  - RELEASE_WAIT: sync=0 increments db_cnt. Reaching DB_CYCLES goes to IDLE, sets level=0, and pulses release. sync=1 returns to HELD and clears db_cnt. The repeat counter is held, not cleared.
- db_cnt width is $clog2(DB_CYCLES+1). rpt_cnt width is $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1). Neither counter wraps; both saturate or reload as specified.
- Repeat:
  - Entering HELD from PRESS_WAIT clears rpt_cnt.
  - When rpt_cnt reaches REPEAT_DELAY, repeat pulses, rpt_cnt reloads to 0, and the phase becomes PERIOD.
  - Thereafter a pulse is issued every REPEAT_PERIOD cycles.
  - The phase resets to DELAY only on a fresh press.
- btn_press and btn_repeat never assert in the same cycle on one channel.
- Reset (any time, including mid-debounce or mid-repeat) clears synchronizers, counters, FSMs (to IDLE), and repeat phase. All outputs go to 0 immediately and asynchronously. A button held through reset deassertion is debounced as a new press.

## Timing
- Raw 0→1 stable from edge k: sync is 1 at edge k+1. btn_level and btn_press assert after edge k+1+DB_CYCLES. Total latency is DB_CYCLES+2 edges.
- Release latency is symmetric at DB_CYCLES+2 edges.
- press, release, and repeat are exactly one cycle wide. They are registered outputs with no combinational path from btn_raw.
- First repeat occurs REPEAT_DELAY cycles after the press pulse. Subsequent repeats are spaced by REPEAT_PERIOD cycles.
- A glitch shorter than DB_CYCLES produces no pulse and no level change.

## Configuration
- BTN_AUTOREPEAT_EN defined: repeat logic is built for channels with REPEAT_MASK bit set. Masked-off channels drive btn_repeat=0.
- BTN_AUTOREPEAT_EN undefined: rpt_cnt and phase state are not instantiated, and btn_repeat is tied to all zeros. Level, press, and release behaviour is unchanged.

## Test plan
Bench parameters: DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, macro defined.
- Reset held low with btn_raw=6'h3F → all outputs 0. After release with btn_raw still high, btn_press=6'h3F pulses once, 6 edges later.
- btn_raw[0] toggled 1/0/1/0 with 2-cycle pulses, then 0 → no btn_press[0], btn_level[0] stays 0.
- btn_raw[2] high for 40 cycles → btn_press[2] once, then btn_repeat[2] at +10, +13, +16, …, then btn_release[2] 6 edges after the raw fall.
- btn_raw[0] (REPEAT_MASK bit 0 clear) held 40 cycles → btn_repeat[0] never asserts.
- btn_raw[3] held, reset pulsed low mid-repeat → outputs clear immediately. After reset release: fresh press pulse, and the first repeat comes a full REPEAT_DELAY later.
- Macro undefined, btn_raw[2] held 40 cycles → btn_repeat stays 0, press and release timing identical to the macro-defined case.
